// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency req/ack imem port and fills IF/ID.
// Optional macro FETCH_ALIGN_CHECK_EN traps odd redirect/exception targets (err, invalid entry).
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002,
  parameter logic [15:0] NOP_INSTR  = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        Redirect_valid,
  input  logic [15:0] Redirect_pc,
  input  logic        Exception,
  output logic        Imem_req,
  output logic [15:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [15:0] Imem_rdata,
  output logic [15:0] Instruction,
  output logic [15:0] Pc_plus2,
  output logic        Valid_PC,
  output logic        Halted,
  output logic        err
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DROP  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pcp2_q, pcp2_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        skid_v_q, skid_v_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [15:0] skid_pcp2_q, skid_pcp2_d;
  logic        skid_ok_q, skid_ok_d;
  logic        bad_q, bad_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        err_q, err_d;
`endif

  logic        flush_s, accept_s, pending_s, tgt_odd_s;
  logic [15:0] target_s, tgt_pc_s, pc_inc_s;
  logic        load_s, load_ok_s;
  logic [15:0] load_instr_s, load_pcp2_s;

  function automatic logic is_halt(input logic [15:0] w);
    return (w[15:11] == 5'b00000);
  endfunction

  assign flush_s   = Exception | Redirect_valid;
  assign target_s  = Exception ? EXC_VECTOR : Redirect_pc;
  assign pc_inc_s  = pc_q + 16'd2;
  assign Imem_req  = rst & (((state_q == S_FETCH) & ~Stall & ~skid_v_q) | (state_q == S_WAIT));
  assign Imem_addr = pc_q;
  assign accept_s  = Imem_req & Imem_ack;
  // A flush must wait out any request the memory has already seen.
  assign pending_s = Imem_req | (state_q == S_DROP);

`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt_odd_s = target_s[0];
  assign tgt_pc_s  = {target_s[15:1], 1'b0};
  assign err       = err_q;
`else
  assign tgt_odd_s = 1'b0;
  assign tgt_pc_s  = target_s;
  assign err       = 1'b0;
`endif

  assign Instruction = instr_q;
  assign Pc_plus2    = pcp2_q;
  assign Valid_PC    = valid_q;
  assign Halted      = halted_q;

  // Next-state logic for the fetch FSM, PC, skid buffer and IF/ID entry.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pcp2_d       = pcp2_q;
    valid_d      = valid_q;
    halted_d     = halted_q;
    skid_v_d     = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pcp2_d  = skid_pcp2_q;
    skid_ok_d    = skid_ok_q;
    bad_d        = bad_q;
`ifdef FETCH_ALIGN_CHECK_EN
    err_d        = err_q;
`endif
    load_s       = 1'b0;
    load_instr_s = Imem_rdata;
    load_pcp2_s  = pc_inc_s;
    load_ok_s    = ~bad_q;

    if (flush_s) begin
      pc_d     = tgt_pc_s;
      instr_d  = NOP_INSTR;
      pcp2_d   = 16'h0000;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      skid_v_d = 1'b0;
      bad_d    = tgt_odd_s;
`ifdef FETCH_ALIGN_CHECK_EN
      err_d    = err_q | tgt_odd_s;
`endif
      state_d  = (pending_s && !Imem_ack) ? S_DROP : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (skid_v_q && !Stall) begin
            // Drain the parked word before issuing any new request.
            load_s       = 1'b1;
            load_instr_s = skid_instr_q;
            load_pcp2_s  = skid_pcp2_q;
            load_ok_s    = skid_ok_q;
            skid_v_d     = 1'b0;
          end else if (accept_s) begin
            load_s = 1'b1;
            pc_d   = pc_inc_s;
            bad_d  = 1'b0;
          end else if (Imem_req) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_WAIT: begin
          if (accept_s) begin
            pc_d    = pc_inc_s;
            bad_d   = 1'b0;
            state_d = S_FETCH;
            if (Stall) begin
              skid_v_d     = 1'b1;
              skid_instr_d = Imem_rdata;
              skid_pcp2_d  = pc_inc_s;
              skid_ok_d    = ~bad_q;
            end else begin
              load_s = 1'b1;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_DROP: begin
          state_d = Imem_ack ? S_FETCH : S_DROP;
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase

      if (load_s) begin
        instr_d = load_instr_s;
        pcp2_d  = load_pcp2_s;
        valid_d = load_ok_s;
        if (load_ok_s && is_halt(load_instr_s)) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          halted_d = halted_q;
        end
      end else begin
        instr_d = instr_q;
      end
    end
  end

  // State and IF/ID registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pcp2_q       <= 16'h0000;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      skid_v_q     <= 1'b0;
      skid_instr_q <= 16'h0000;
      skid_pcp2_q  <= 16'h0000;
      skid_ok_q    <= 1'b0;
      bad_q        <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pcp2_q       <= pcp2_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      skid_v_q     <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pcp2_q  <= skid_pcp2_d;
      skid_ok_q    <= skid_ok_d;
      bad_q        <= bad_d;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q        <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: variable-latency memory model plus an IF/ID scoreboard.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        Stall;
  logic        Redirect_valid;
  logic [15:0] Redirect_pc;
  logic        Exception;
  logic        Imem_req;
  logic [15:0] Imem_addr;
  logic        Imem_ack;
  logic [15:0] Imem_rdata;
  logic [15:0] Instruction;
  logic [15:0] Pc_plus2;
  logic        Valid_PC;
  logic        Halted;
  logic        err;

  int tests = 0;
  int fails = 0;

  // memory model state
  int          ack_delay;
  int          cnt_q;
  logic        pend_q;
  logic [15:0] addr_l;
  logic        abcd_en;
  logic [15:0] fa;

  logic [31:0] exp_q[$];
  logic [31:0] prev_ifid;
  logic [31:0] got;

  fetch_stage dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Redirect_valid(Redirect_valid),
    .Redirect_pc(Redirect_pc), .Exception(Exception), .Imem_req(Imem_req),
    .Imem_addr(Imem_addr), .Imem_ack(Imem_ack), .Imem_rdata(Imem_rdata),
    .Instruction(Instruction), .Pc_plus2(Pc_plus2), .Valid_PC(Valid_PC),
    .Halted(Halted), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: acks after ack_delay waiting cycles (0 = same cycle), survives a squashed request.
  always_comb Imem_ack = rst && (Imem_req || pend_q) && (cnt_q >= ack_delay);

  always_comb begin
    fa = pend_q ? addr_l : Imem_addr;
    if (fa == 16'h0004 && abcd_en) Imem_rdata = 16'hABCD;
    else if (fa == 16'h0010)       Imem_rdata = 16'h0000;
    else                           Imem_rdata = 16'h1000 + {1'b0, fa[15:1]};
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= 0;
      pend_q <= 1'b0;
      addr_l <= 16'h0000;
    end else if (Imem_ack) begin
      cnt_q  <= 0;
      pend_q <= 1'b0;
    end else if (Imem_req || pend_q) begin
      cnt_q  <= cnt_q + 1;
      pend_q <= 1'b1;
      if (!pend_q) addr_l <= Imem_addr;
    end
  end

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Scoreboard: every new valid IF/ID entry must match the oldest expected one.
  always @(negedge clk) begin
    #2;
    if (rst && Valid_PC && ({Instruction, Pc_plus2} != prev_ifid)) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL ifid_unexpected: observed %h/%h expected no entry", Instruction, Pc_plus2);
      end
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        chk16("sb_instr", Instruction, got[31:16]);
        chk16("sb_pcp2", Pc_plus2, got[15:0]);
      end
    end
    prev_ifid = {Instruction, Pc_plus2};
  end

  initial begin
    rst = 1'b0; Stall = 1'b0; Redirect_valid = 1'b0; Redirect_pc = 16'h0000;
    Exception = 1'b0; ack_delay = 0; abcd_en = 1'b0; prev_ifid = 32'h0;

    // reset values
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_req", Imem_req, 1'b0);
    chk16("rst_instr", Instruction, 16'h0800);
    chk16("rst_pcp2", Pc_plus2, 16'h0000);
    chk1("rst_valid", Valid_PC, 1'b0);
    chk1("rst_halted", Halted, 1'b0);
    chk1("rst_err", err, 1'b0);

    // zero-latency streaming
    @(negedge clk); rst = 1'b1;
    exp_q.push_back({16'h1000, 16'h0002});
    exp_q.push_back({16'h1001, 16'h0004});
    exp_q.push_back({16'h1002, 16'h0006});
    #1; chk1("t1_req", Imem_req, 1'b1); chk16("t1_addr0", Imem_addr, 16'h0000);
    @(negedge clk); #1;
    chk16("t1_addr2", Imem_addr, 16'h0002); chk16("t1_instr", Instruction, 16'h1000);
    chk16("t1_pcp2", Pc_plus2, 16'h0002); chk1("t1_valid", Valid_PC, 1'b1);
    @(negedge clk); #1; chk16("t1_addr4", Imem_addr, 16'h0004);
    @(negedge clk); Stall = 1'b1; #1;
    chk1("t1_stall_req", Imem_req, 1'b0); chk16("t1_instr3", Instruction, 16'h1002);

    // latency: request held three cycles, single capture
    @(negedge clk); rst = 1'b0; ack_delay = 2; Stall = 1'b0;
    #1; chk16("t2_rst_instr", Instruction, 16'h0800);
    @(negedge clk); rst = 1'b1; exp_q.push_back({16'h1000, 16'h0002});
    #1; chk1("t2_req_c1", Imem_req, 1'b1); chk16("t2_addr_c1", Imem_addr, 16'h0000);
    chk1("t2_noack_c1", Imem_ack, 1'b0);
    @(negedge clk); #1;
    chk1("t2_req_c2", Imem_req, 1'b1); chk16("t2_addr_c2", Imem_addr, 16'h0000);
    chk1("t2_valid_c2", Valid_PC, 1'b0);
    @(negedge clk); #1;
    chk1("t2_req_c3", Imem_req, 1'b1); chk16("t2_addr_c3", Imem_addr, 16'h0000);
    chk1("t2_ack_c3", Imem_ack, 1'b1);
    @(negedge clk); Stall = 1'b1; abcd_en = 1'b1; #1;
    chk16("t2_pc", Imem_addr, 16'h0002); chk16("t2_instr", Instruction, 16'h1000);

    // stall over an outstanding fetch of 0x0004
    @(negedge clk); Stall = 1'b0; exp_q.push_back({16'h1001, 16'h0004});
    #1; chk16("t3_addr2", Imem_addr, 16'h0002);
    @(negedge clk);
    @(negedge clk); #1; chk1("t3_ack2", Imem_ack, 1'b1);
    @(negedge clk); exp_q.push_back({16'hABCD, 16'h0006});
    #1; chk16("t3_addr4", Imem_addr, 16'h0004); chk16("t3_instr", Instruction, 16'h1001);
    @(negedge clk); Stall = 1'b1;
    #1; chk1("t3_wait_req", Imem_req, 1'b1); chk16("t3_wait_addr", Imem_addr, 16'h0004);
    @(negedge clk); #1; chk1("t3_ack_in_stall", Imem_ack, 1'b1);
    @(negedge clk); #1; chk1("t3_skid_req", Imem_req, 1'b0);
    chk16("t3_hold1", Instruction, 16'h1001);
    @(negedge clk); #1; chk16("t3_hold2", Instruction, 16'h1001);
    @(negedge clk); Stall = 1'b0; #1; chk1("t3_drain_req", Imem_req, 1'b0);
    @(negedge clk); Stall = 1'b1; #1;
    chk16("t3_abcd", Instruction, 16'hABCD); chk16("t3_abcd_pcp2", Pc_plus2, 16'h0006);
    chk16("t3_no_refetch", Imem_addr, 16'h0006);

    // redirect / exception while waiting
    @(negedge clk); Stall = 1'b0; exp_q.push_back({16'h1003, 16'h0008});
    #1; chk16("t4_addr6", Imem_addr, 16'h0006);
    @(negedge clk);
    @(negedge clk); #1; chk1("t4_ack6", Imem_ack, 1'b1);
    @(negedge clk); #1; chk16("t4_addr8", Imem_addr, 16'h0008);
    @(negedge clk); Redirect_valid = 1'b1; Redirect_pc = 16'h0040;
    #1; chk1("t4_wait_req", Imem_req, 1'b1);
    @(negedge clk); Redirect_valid = 1'b0; #1;
    chk1("t4_drop_req", Imem_req, 1'b0); chk16("t4_nop", Instruction, 16'h0800);
    chk1("t4_nop_valid", Valid_PC, 1'b0); chk16("t4_nop_pcp2", Pc_plus2, 16'h0000);
    chk1("t4_late_ack", Imem_ack, 1'b1);
    @(negedge clk); #1; chk1("t4_req40", Imem_req, 1'b1); chk16("t4_addr40", Imem_addr, 16'h0040);
    @(negedge clk); Exception = 1'b1; Redirect_valid = 1'b1; Redirect_pc = 16'h0080;
    #1; chk16("t4_wait40", Imem_addr, 16'h0040);
    @(negedge clk); Exception = 1'b0; Redirect_valid = 1'b0;
    #1; chk1("t4_drop2_req", Imem_req, 1'b0);
    @(negedge clk); exp_q.push_back({16'h1001, 16'h0004});
    #1; chk1("t4_exc_req", Imem_req, 1'b1); chk16("t4_exc_addr", Imem_addr, 16'h0002);

    // halt word at 0x0010, then redirect out
    @(negedge clk);
    @(negedge clk); ack_delay = 0; #1; chk1("t5_ack2", Imem_ack, 1'b1);
    @(negedge clk); Stall = 1'b1; Redirect_valid = 1'b1; Redirect_pc = 16'h0010;
    #1; chk16("t5_instr", Instruction, 16'h1001);
    @(negedge clk); Stall = 1'b0; Redirect_valid = 1'b0; exp_q.push_back({16'h0000, 16'h0012});
    #1; chk16("t5_addr10", Imem_addr, 16'h0010); chk1("t5_valid0", Valid_PC, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk1("t5_halted", Halted, 1'b1); chk1("t5_halt_req", Imem_req, 1'b0);
    end
    @(negedge clk); Redirect_valid = 1'b1; Redirect_pc = 16'h0020;
    @(negedge clk); Redirect_valid = 1'b0; exp_q.push_back({16'h1010, 16'h0022});
    #1; chk1("t5_unhalt", Halted, 1'b0); chk1("t5_req20", Imem_req, 1'b1);
    chk16("t5_addr20", Imem_addr, 16'h0020);
    @(negedge clk); Stall = 1'b1; #1; chk16("t5_instr20", Instruction, 16'h1010);

    // PC wrap
    @(negedge clk); Redirect_valid = 1'b1; Redirect_pc = 16'hFFFE;
    @(negedge clk); Redirect_valid = 1'b0; Stall = 1'b0; exp_q.push_back({16'h8FFF, 16'h0000});
    #1; chk16("t6_addrFFFE", Imem_addr, 16'hFFFE);
    @(negedge clk); Stall = 1'b1; #1;
    chk16("t6_wrap", Imem_addr, 16'h0000); chk16("t6_pcp2", Pc_plus2, 16'h0000);

    // odd redirect target
    @(negedge clk); Redirect_valid = 1'b1; Redirect_pc = 16'h0031;
    @(negedge clk); Redirect_valid = 1'b0; Stall = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    #1; chk16("t7_align_addr", Imem_addr, 16'h0030); chk1("t7_err", err, 1'b1);
    @(negedge clk); Stall = 1'b1; #1;
    chk1("t7_invalid", Valid_PC, 1'b0); chk16("t7_instr", Instruction, 16'h1018);
    chk1("t7_err_sticky", err, 1'b1);
`else
    exp_q.push_back({16'h1018, 16'h0033});
    #1; chk16("t7_odd_addr", Imem_addr, 16'h0031); chk1("t7_err0", err, 1'b0);
    @(negedge clk); Stall = 1'b1; #1;
    chk1("t7_valid", Valid_PC, 1'b1); chk16("t7_instr", Instruction, 16'h1018);
`endif

    // reset while waiting
    @(negedge clk); Stall = 1'b0; ack_delay = 2; #1; chk1("t8_req", Imem_req, 1'b1);
    @(negedge clk); #2; rst = 1'b0; #1;
    chk1("t8_rst_req", Imem_req, 1'b0); chk16("t8_rst_instr", Instruction, 16'h0800);
    chk1("t8_rst_valid", Valid_PC, 1'b0); chk1("t8_rst_err", err, 1'b0);
    @(negedge clk); rst = 1'b1; exp_q.push_back({16'h1000, 16'h0002});
    #1; chk16("t8_addr0", Imem_addr, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); Stall = 1'b1; #1;
    chk16("t8_instr", Instruction, 16'h1000); chk1("t8_valid", Valid_PC, 1'b1);

    repeat (3) @(negedge clk);
    #3;
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL sb_leftover: observed %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of decode. Owns the PC and drives a request/acknowledge instruction-memory port with variable latency. Registers the fetched word into the IF/ID boundary as Instruction/Pc_plus2/Valid_PC for decode. Handles stall, branch/jump/RTI redirect, SIIC exception vectoring and halt.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset
EXC_VECTOR, 16'h0002, PC loaded on Exception
NOP_INSTR, 16'h0800, bubble word placed in IF/ID on flush/reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
Stall  in  1  hazard hold: IF/ID and PC frozen
Redirect_valid  in  1  taken branch/jump/RTI from execute
Redirect_pc  in  16  redirect target
Exception  in  1  SIIC taken; vector to EXC_VECTOR
Imem_req  out  1  fetch request
Imem_addr  out  16  fetch address
Imem_ack  in  1  read data valid (may be same cycle as req)
Imem_rdata  in  16  fetched word
Instruction  out  16  IF/ID instruction to decode
Pc_plus2  out  16  IF/ID PC+2 of that instruction
Valid_PC  out  1  IF/ID entry holds a real instruction
Halted  out  1  fetch stopped on HALT
err  out  1  sticky fetch error

Behaviour:
- Reset (rst low, async): PC=RESET_PC, Instruction=NOP_INSTR, Pc_plus2=0, Valid_PC=0, Halted=0, err=0, skid empty, state FETCH. Imem_req=0 while in reset.
- States: FETCH, WAIT, DROP, HALT.
- FETCH: Imem_req=1, Imem_addr=PC, unless Stall or skid full (then Imem_req=0). Ack same cycle -> capture; else -> WAIT.
- WAIT: Imem_req held 1, Imem_addr stable at PC until Imem_ack. No new request while outstanding.
- Capture on ack: if not Stall, IF/ID <= {Imem_rdata, PC+2, 1} next edge. If Stall, word goes to one-entry skid buffer; IF/ID unchanged. PC <= PC+2 (16-bit wrap, 16'hFFFE -> 16'h0000) on each accepted ack.
- Stall low with skid full: IF/ID loads skid first (1 cycle), skid clears, fetch resumes next cycle. Stall never drops data: no word lost or duplicated.
- Priority: rst > Exception > Redirect_valid > Stall > normal.
- Exception/Redirect (sampled each edge, Stall ignored): PC <= EXC_VECTOR or Redirect_pc; IF/ID <= {NOP_INSTR, 0, 0}; skid cleared; Halted cleared. If a request is outstanding (WAIT, or req this cycle without ack) -> DROP. Else -> FETCH.
- DROP: Imem_req=0; wait for Imem_ack, discard data, PC untouched -> FETCH. Redirect in DROP only updates PC.
- HALT: entered when the word loaded into IF/ID has opcode [15:11]==5'b00000. Imem_req=0, Halted=1, IF/ID holds the halt word. Exit only via Exception/Redirect (older branch squashes speculative halt) or reset.
- Reset mid-WAIT: state cleared immediately; memory model must tolerate abandoned request.

Optional Feature:
FETCH_ALIGN_CHECK_EN: when defined, a redirect/exception target with bit 0 set forces PC bit 0 to 0, sets err (sticky until reset), and that fetch's IF/ID entry is loaded with Valid_PC=0. When undefined, targets are used unmodified and err is constant 0.

Test Plan:
- Reset release, ack same cycle, memory words 0x1000,0x1001,0x1002 -> Imem_addr 0,2,4 on consecutive cycles; Instruction 0x1000 with Pc_plus2=2, Valid_PC=1 one cycle after first ack.
- Ack latency 3 -> Imem_req/Imem_addr=0x0000 held 3 cycles; single capture; PC becomes 0x0002.
- Stall asserted during outstanding fetch of 0x0004 (word 0xABCD) for 4 cycles -> IF/ID unchanged; Instruction=0xABCD cycle after Stall drops; no duplicate fetch of 0x0004.
- Redirect_pc=0x0040 while WAIT at 0x0008 -> next IF/ID = NOP_INSTR, Valid_PC=0; late ack discarded; next Imem_addr=0x0040. Simultaneous Exception -> Imem_addr=0x0002 instead.
- Fetch word 0x0000 at 0x0010 -> Halted=1, Imem_req=0 forever; then Redirect_pc=0x0020 -> Halted=0, fetch 0x0020.
- PC=0xFFFE fetch -> next Imem_addr=0x0000; with FETCH_ALIGN_CHECK_EN, Redirect_pc=0x0031 -> Imem_addr=0x0030, err=1, Valid_PC=0.
